// File: rtl/alu_seq.sv
// alu_seq: per-lane sequential ALU for a compute core.
//
// Single-cycle ops cover ADD, SUB, MUL, AND, OR and XOR, the NZP compare,
// and DIV/REM by zero. DIV/REM with a nonzero divisor run on a restoring
// divider that takes DATA_W cycles. All outputs are registered. done pulses
// for one cycle each time alu_out/overflow/nzp update.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   enable      lane (thread) active
//   core_state  core pipeline state; issue is allowed only in EXEC_STATE
//   opcode      000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 REM, 101 AND, 110 OR, 111 XOR
//   output_mux  1 = compare (NZP) result; opcode ignored
//   rs, rt      operands A and B
//   alu_out     registered result
//   nzp         registered {N,Z,P} from the last compare
//   overflow    carry/borrow/product-overflow/divide-by-zero flag of the last op
//   busy        divider running; issues are dropped while high
//   done        one-cycle pulse when the results update
module alu_seq #(
   parameter int unsigned               DATA_W     = 8,
   parameter int unsigned               STATE_W    = 3,
   parameter logic [STATE_W-1:0]        EXEC_STATE = 3'b101,
   parameter bit                        SIGNED_CMP = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [STATE_W-1:0]  core_state,
   input  logic [2:0]          opcode,
   input  logic                output_mux,
   input  logic [DATA_W-1:0]   rs,
   input  logic [DATA_W-1:0]   rt,
   output logic [DATA_W-1:0]   alu_out,
   output logic [2:0]          nzp,
   output logic                overflow,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpMul = 3'b010;
   localparam logic [2:0] OpDiv = 3'b011;
   localparam logic [2:0] OpRem = 3'b100;
   localparam logic [2:0] OpAnd = 3'b101;
   localparam logic [2:0] OpOr  = 3'b110;
   localparam logic [2:0] OpXor = 3'b111;

   typedef enum logic {StIdle, StDivide} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   alu_out_q, alu_out_d;
   logic [2:0]          nzp_q, nzp_d;
   logic                overflow_q, overflow_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   // Divider datapath: quo_q starts as the dividend and fills with quotient bits.
   logic [DATA_W-1:0]   quo_q, quo_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   dvsr_q, dvsr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                op_rem_q, op_rem_d;

   logic                  issue;
   logic [DATA_W:0]       sum;
   logic [DATA_W-1:0]     diff;
   logic [2*DATA_W-1:0]   prod;
   logic                  cmp_lt, cmp_gt, cmp_eq;
   logic [2:0]            cmp_nzp;
   logic [DATA_W:0]       rem_shift;
   logic [DATA_W:0]       rem_diff;
   logic [DATA_W:0]       rem_step;
   logic                  rem_fits;
   logic [DATA_W-1:0]     quo_step;
   logic                  unused_rem_msb;

   assign issue = enable && (core_state == EXEC_STATE) && (state_q == StIdle);

   assign sum  = {1'b0, rs} + {1'b0, rt};
   assign diff = rs - rt;
   assign prod = {{DATA_W{1'b0}}, rs} * {{DATA_W{1'b0}}, rt};

   always_comb begin
      if (SIGNED_CMP) begin
         cmp_lt = $signed(rs) < $signed(rt);
         cmp_gt = $signed(rs) > $signed(rt);
      end else begin
         cmp_lt = rs < rt;
         cmp_gt = rs > rt;
      end
   end
   assign cmp_eq  = (rs == rt);
   assign cmp_nzp = {cmp_lt, cmp_eq, cmp_gt};

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign rem_shift = {rem_q, quo_q[DATA_W-1]};
   assign rem_diff  = rem_shift - {1'b0, dvsr_q};
   assign rem_fits  = rem_shift >= {1'b0, dvsr_q};
   assign rem_step  = rem_fits ? rem_diff : rem_shift;
   assign quo_step  = {quo_q[DATA_W-2:0], rem_fits};
   // After a restoring step the remainder is below the divisor, so its MSB is 0.
   assign unused_rem_msb = rem_step[DATA_W];

   always_comb begin
      state_d    = state_q;
      alu_out_d  = alu_out_q;
      nzp_d      = nzp_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvsr_d     = dvsr_q;
      cnt_d      = cnt_q;
      op_rem_d   = op_rem_q;

      unique case (state_q)
         StIdle: begin
            if (issue) begin
               done_d = 1'b1;
               if (output_mux) begin
                  alu_out_d  = {{(DATA_W-3){1'b0}}, cmp_nzp};
                  nzp_d      = cmp_nzp;
                  overflow_d = 1'b0;
               end else begin
                  unique case (opcode)
                     OpAdd: begin
                        alu_out_d  = sum[DATA_W-1:0];
                        overflow_d = sum[DATA_W];
                     end
                     OpSub: begin
                        alu_out_d  = diff;
                        overflow_d = rs < rt;
                     end
                     OpMul: begin
                        alu_out_d  = prod[DATA_W-1:0];
                        overflow_d = |prod[2*DATA_W-1:DATA_W];
                     end
                     OpDiv, OpRem: begin
                        if (rt == '0) begin
                           alu_out_d  = (opcode == OpRem) ? rs : '0;
                           overflow_d = 1'b1;
                        end else begin
                           // Result arrives after DATA_W divider steps.
                           done_d   = 1'b0;
                           state_d  = StDivide;
                           busy_d   = 1'b1;
                           quo_d    = rs;
                           rem_d    = '0;
                           dvsr_d   = rt;
                           cnt_d    = CNT_W'(DATA_W);
                           op_rem_d = (opcode == OpRem);
                        end
                     end
                     OpAnd: begin
                        alu_out_d  = rs & rt;
                        overflow_d = 1'b0;
                     end
                     OpOr: begin
                        alu_out_d  = rs | rt;
                        overflow_d = 1'b0;
                     end
                     OpXor: begin
                        alu_out_d  = rs ^ rt;
                        overflow_d = 1'b0;
                     end
                     default: begin
                        alu_out_d = alu_out_q;
                     end
                  endcase
               end
            end
         end
         StDivide: begin
            quo_d = quo_step;
            rem_d = rem_step[DATA_W-1:0];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d    = StIdle;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               overflow_d = 1'b0;
               alu_out_d  = op_rem_q ? rem_step[DATA_W-1:0] : quo_step;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         alu_out_q  <= '0;
         nzp_q      <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         cnt_q      <= '0;
         op_rem_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_out_q  <= alu_out_d;
         nzp_q      <= nzp_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dvsr_q     <= dvsr_d;
         cnt_q      <= cnt_d;
         op_rem_q   <= op_rem_d;
      end
   end

   assign alu_out  = alu_out_q;
   assign nzp      = nzp_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: two instances (unsigned and signed compare) share
// stimulus. Expected results are queued at issue time from an arithmetic
// model; a negedge monitor pops and compares on each done pulse and checks
// that outputs hold in between.
module tb_alu_seq;

   localparam int         W    = 8;
   localparam logic [2:0] EXEC = 3'b101;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3;
   localparam logic [2:0] REM = 3'd4, AND = 3'd5, OR = 3'd6, XOR = 3'd7;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [2:0]   core_state;
   logic [2:0]   opcode;
   logic         output_mux;
   logic [W-1:0] rs, rt;

   logic [W-1:0] alu_out_u, alu_out_s;
   logic [2:0]   nzp_u, nzp_s;
   logic         overflow_u, overflow_s;
   logic         busy_u, busy_s;
   logic         done_u, done_s;

   always #5 clk = ~clk;

   alu_seq #(.DATA_W(W), .STATE_W(3), .EXEC_STATE(EXEC), .SIGNED_CMP(1'b0)) dut_u (
      .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
      .opcode(opcode), .output_mux(output_mux), .rs(rs), .rt(rt),
      .alu_out(alu_out_u), .nzp(nzp_u), .overflow(overflow_u),
      .busy(busy_u), .done(done_u)
   );

   alu_seq #(.DATA_W(W), .STATE_W(3), .EXEC_STATE(EXEC), .SIGNED_CMP(1'b1)) dut_s (
      .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
      .opcode(opcode), .output_mux(output_mux), .rs(rs), .rt(rt),
      .alu_out(alu_out_s), .nzp(nzp_s), .overflow(overflow_s),
      .busy(busy_s), .done(done_s)
   );

   typedef struct packed {
      logic [W-1:0] alu;
      logic [2:0]   nzp;
      logic         ovf;
   } exp_t;

   exp_t       q[2][$];
   exp_t       hold[2];
   logic [2:0] nzp_m[2];
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         mon_on   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the arithmetic rules, lane l: 0 unsigned cmp, 1 signed cmp.
   function automatic exp_t model(input logic [2:0] op, input logic mux, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input int l, input logic [2:0] prev);
      exp_t e;
      int   ai, bi, s;
      e.nzp = prev;
      e.ovf = 1'b0;
      if (mux) begin
         ai = (l == 1) ? int'($signed(a)) : int'(a);
         bi = (l == 1) ? int'($signed(b)) : int'(b);
         e.nzp = {ai < bi, ai == bi, ai > bi};
         e.alu = {5'b0, e.nzp};
      end else begin
         case (op)
            ADD: begin s = int'(a) + int'(b); e.alu = s[W-1:0]; e.ovf = s > 255; end
            SUB: begin s = int'(a) - int'(b); e.alu = s[W-1:0]; e.ovf = a < b; end
            MUL: begin s = int'(a) * int'(b); e.alu = s[W-1:0]; e.ovf = s > 255; end
            DIV: begin e.alu = (b == 0) ? 8'd0 : a / b; e.ovf = (b == 0); end
            REM: begin e.alu = (b == 0) ? a : a % b; e.ovf = (b == 0); end
            AND: e.alu = a & b;
            OR:  e.alu = a | b;
            default: e.alu = a ^ b;
         endcase
      end
      return e;
   endfunction

   task automatic mon_lane(input int l, input logic [W-1:0] a, input logic [2:0] z,
                           input logic o, input logic b, input logic d);
      exp_t  e;
      string tag;
      tag = (l == 1) ? "s" : "u";
      if (d) begin
         chk({"done_has_pending_op_", tag}, int'(q[l].size() > 0), 1);
         if (q[l].size() > 0) begin
            e = q[l].pop_front();
            chk({"alu_out_", tag}, int'(a), int'(e.alu));
            chk({"nzp_", tag}, int'(z), int'(e.nzp));
            chk({"overflow_", tag}, int'(o), int'(e.ovf));
            chk({"busy_at_done_", tag}, int'(b), 0);
            hold[l] = e;
         end
      end else begin
         chk({"hold_alu_out_", tag}, int'(a), int'(hold[l].alu));
         chk({"hold_nzp_", tag}, int'(z), int'(hold[l].nzp));
         chk({"hold_overflow_", tag}, int'(o), int'(hold[l].ovf));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            mon_lane(0, alu_out_u, nzp_u, overflow_u, busy_u, done_u);
            mon_lane(1, alu_out_s, nzp_s, overflow_s, busy_s, done_s);
         end
      end
   end

   task automatic chk_all_zero(input string name);
      chk({name, "_alu_out"}, int'(alu_out_u) + int'(alu_out_s), 0);
      chk({name, "_nzp"}, int'(nzp_u) + int'(nzp_s), 0);
      chk({name, "_overflow"}, int'(overflow_u) + int'(overflow_s), 0);
      chk({name, "_busy"}, int'(busy_u) + int'(busy_s), 0);
      chk({name, "_done"}, int'(done_u) + int'(done_s), 0);
   endtask

   // Called at a negedge; reset is sampled at the following posedge.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int l = 0; l < 2; l++) begin
         q[l].delete();
         hold[l]  = '0;
         nzp_m[l] = 3'b000;
      end
      @(negedge clk);
      chk_all_zero("reset");
   endtask

   // Drives one op; with poke set, attempts an ADD issue mid-divide.
   task automatic issue(input logic [2:0] op, input logic mux, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic en, input logic [2:0] cs,
                        input bit poke);
      bit   issued, is_div;
      exp_t e;
      issued = en && (cs == EXEC);
      is_div = issued && !mux && (op == DIV || op == REM) && (b != 0);
      enable = en; core_state = cs; opcode = op; output_mux = mux; rs = a; rt = b;
      if (issued) begin
         for (int l = 0; l < 2; l++) begin
            e = model(op, mux, a, b, l, nzp_m[l]);
            nzp_m[l] = e.nzp;
            q[l].push_back(e);
         end
      end
      @(posedge clk);
      #1;
      enable = 1'b0;
      if (is_div) begin
         for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            chk("busy_during_divide", int'(busy_u) + int'(busy_s), 2);
            chk("done_during_divide", int'(done_u) + int'(done_s), 0);
            opcode = 3'($urandom_range(0, 7));
            rs = 8'($urandom); rt = 8'($urandom);
            enable = poke && (i == 3);
            core_state = EXEC;
            if (enable) opcode = ADD;
         end
         @(negedge clk);
         enable = 1'b0;
         chk("busy_after_divide", int'(busy_u) + int'(busy_s), 0);
         chk("done_after_divide", int'(done_u) + int'(done_s), 2);
      end else begin
         @(negedge clk);
         chk("done_single", int'(done_u) + int'(done_s), issued ? 2 : 0);
         chk("busy_single", int'(busy_u) + int'(busy_s), 0);
      end
   endtask

   initial begin
      logic [2:0] op, cs;
      logic       mux, en;
      logic [W-1:0] a, b;

      reset = 1'b1; enable = 1'b0; core_state = 3'b000; opcode = ADD;
      output_mux = 1'b0; rs = '0; rt = '0;
      for (int l = 0; l < 2; l++) begin
         hold[l] = '0;
         nzp_m[l] = 3'b000;
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("initial_reset");
      mon_on = 1'b1;

      issue(ADD, 1'b0, 8'd200, 8'd100, 1'b1, EXEC, 1'b0);
      issue(SUB, 1'b0, 8'd5, 8'd9, 1'b1, EXEC, 1'b0);
      issue(MUL, 1'b0, 8'd20, 8'd13, 1'b1, EXEC, 1'b0);
      issue(AND, 1'b0, 8'hF0, 8'h3C, 1'b1, EXEC, 1'b0);
      issue(ADD, 1'b1, 8'h80, 8'h01, 1'b1, EXEC, 1'b0);
      issue(ADD, 1'b1, 8'd7, 8'd7, 1'b1, EXEC, 1'b0);
      issue(DIV, 1'b0, 8'd200, 8'd7, 1'b1, EXEC, 1'b1);
      issue(REM, 1'b0, 8'd200, 8'd7, 1'b1, EXEC, 1'b0);
      issue(DIV, 1'b0, 8'd50, 8'd0, 1'b1, EXEC, 1'b0);
      issue(REM, 1'b0, 8'd50, 8'd0, 1'b1, EXEC, 1'b0);
      issue(OR, 1'b0, 8'h12, 8'h34, 1'b0, EXEC, 1'b0);
      issue(XOR, 1'b0, 8'h12, 8'h34, 1'b1, 3'b100, 1'b0);
      repeat (2) @(negedge clk);
      issue(XOR, 1'b0, 8'h5A, 8'hFF, 1'b1, EXEC, 1'b0);
      do_reset();

      // Abort a divide with reset; no done may follow for it.
      enable = 1'b1; core_state = EXEC; opcode = DIV; output_mux = 1'b0;
      rs = 8'd200; rt = 8'd7;
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("busy_before_abort", int'(busy_u) + int'(busy_s), 2);
      end
      do_reset();
      repeat (W + 2) @(negedge clk);
      issue(DIV, 1'b0, 8'd9, 8'd3, 1'b1, EXEC, 1'b0);

      for (int n = 0; n < 60; n++) begin
         op  = 3'($urandom_range(0, 7));
         mux = ($urandom_range(0, 3) == 0);
         a   = 8'($urandom);
         b   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         en  = ($urandom_range(0, 7) != 0);
         cs  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : EXEC;
         issue(op, mux, a, b, en, cs, ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      chk("queue_drained_u", q[0].size(), 0);
      chk("queue_drained_s", q[1].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the per-thread 8-bit core ALU.
- Adds:
  - configurable data width;
  - a wider opcode set (logic ops, remainder);
  - a working multi-cycle restoring divider;
  - an overflow/carry flag;
  - busy/done handshake signals.
- One instance per thread lane inside a compute core.
- Issues only during the core's EXECUTE state.
- Results feed the register-file write-back path.

Parameters:
- DATA_W, 8: operand/result width; must be ≥ 4.
- STATE_W, 3: width of core_state.
- EXEC_STATE, 3'b101: core_state value that permits issue.
- SIGNED_CMP, 0: compare mode. 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: lane active (thread enabled).
- core_state, input, STATE_W: core pipeline state.
- opcode, input, 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 REM, 101 AND, 110 OR, 111 XOR.
- output_mux, input, 1: 1 = compare (NZP) result; opcode is ignored.
- rs, input, DATA_W: operand A.
- rt, input, DATA_W: operand B.
- alu_out, output, DATA_W: registered result.
- nzp, output, 3: registered {N,Z,P} from the last compare.
- overflow, output, 1: registered flag for the last completed op.
- busy, output, 1: divider in progress; new issues ignored.
- done, output, 1: one-cycle pulse when alu_out/overflow/nzp update.

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - alu_out=0, nzp=0, overflow=0, busy=0, done=0.
  - FSM goes to IDLE.
  - Aborts any in-flight divide; no done pulse is produced for it.
- Issue condition: enable && core_state==EXEC_STATE && state==IDLE, sampled at edge T.
  - If not met, all outputs hold, except done, which is 0.
- FSM states: IDLE and DIVIDE.
  - IDLE -> DIVIDE: issue with output_mux=0, opcode DIV/REM, rt≠0.
  - DIVIDE -> IDLE: after DATA_W iterations.
- Single-cycle ops (compare, ADD, SUB, MUL, logic ops, and DIV/REM with rt=0):
  - Result registered at edge T; visible with done=1 during cycle T+1.
- Compare (output_mux=1):
  - alu_out = {zeros, N, Z, P}; nzp = {N, Z, P}; overflow = 0.
  - Z = (rs==rt); N = (rs<rt); P = (rs>rt). Exactly one of N/Z/P is set.
  - The < and > comparisons are unsigned when SIGNED_CMP=0, signed when SIGNED_CMP=1.
  - nzp is updated only by compare.
- Arithmetic is unsigned. Results are truncated to DATA_W bits.
- Overflow flag per op:
  - ADD: carry-out.
  - SUB: borrow (rs<rt).
  - MUL: upper DATA_W bits of the 2·DATA_W product are nonzero.
  - AND/OR/XOR: 0.
  - DIV/REM: 1 iff rt=0.
- Division by zero:
  - DIV gives alu_out=0; REM gives alu_out=rs.
  - overflow=1; single-cycle; no busy.
- Divide (rt≠0):
  - At T: latch rs/rt/opcode and load an iteration counter with DATA_W.
  - busy=1 during cycles T+1..T+DATA_W. The restoring divider produces one quotient bit per cycle, MSB first.
  - Final result is written at the edge ending cycle T+DATA_W, so alu_out and done=1 are seen in cycle T+DATA_W+1, with busy=0 in that cycle.
  - DIV gives the quotient; REM gives the remainder; overflow=0.
  - Internal width: DATA_W+1-bit partial remainder.
- During DIVIDE:
  - Changes to rs/rt/opcode/enable/core_state do not affect the result (operands are latched).
  - Issue attempts are ignored; no queueing.
- Back-to-back: a new issue is accepted in the same cycle done is high, since state is IDLE.
- done is high for exactly one cycle per accepted op.

Test Plan (DATA_W=8):
- Reset and single-cycle ops:
  - Reset mid-run -> all outputs 0.
  - ADD 200+100 in EXEC -> next cycle alu_out=44, overflow=1, done=1.
  - SUB 5-9 -> alu_out=252, overflow=1.
  - MUL 20×13 -> alu_out=4, overflow=1.
  - AND 0xF0&0x3C -> 0x30, overflow=0.
- Compare mode:
  - rs=0x80, rt=0x01, output_mux=1, SIGNED_CMP=0 -> nzp=001, alu_out=0x01.
  - Same with SIGNED_CMP=1 -> nzp=100, alu_out=0x04.
  - rs=rt=7 -> nzp=010.
- Divide:
  - DIV 200/7 issued at T -> busy=1 for cycles T+1..T+8, alu_out=28, done=1 at T+9.
  - REM 200/7 -> alu_out=4.
  - Issue ADD at T+3 -> ignored; no extra done pulse.
- Divide by zero:
  - DIV 50/0 -> alu_out=0, overflow=1, done next cycle, busy never asserted.
  - REM 50/0 -> alu_out=50, overflow=1.
- Gating:
  - enable=0, or core_state≠3'b101 -> no update, done=0, alu_out holds the previous value.
- Reset mid-divide:
  - Reset asserted at T+4 -> next cycle busy=0, alu_out=0.
  - No done pulse follows.
  - A fresh DIV 9/3 afterwards -> alu_out=3.
